// File: rtl/alu_result_stage.sv
// ============================================================================
// alu_result_stage
//
// Registers the result of the 32-bit ALU together with its condition flags.
// The stage is a two-entry skid buffer. The "main" entry drives the outputs.
// The "skid" entry catches one extra result when the downstream stalls.
// in_ready is therefore a pure function of registered state (and rst).
//
// Handshake semantics (both sides):
//   accept  = in_valid  & in_ready   -- a result is taken on the next edge
//   deliver = out_valid & out_ready  -- the main entry is consumed on the next edge
//   A producer holds its payload stable while valid=1 and ready=0.
//   in_ready never depends combinationally on in_valid or out_ready.
//   Outputs hold steady while out_valid=1 and out_ready=0.
//
// Ports:
//   clk         in   system clock, all state updates on its rising edge
//   rst         in   synchronous active-high reset
//   in_valid    in   upstream ALU result valid this cycle
//   in_ready    out  stage can accept a result this cycle
//   d[31:0]     in   ALU result word
//   cout        in   carry out of bit 31
//   a31, b31    in   sign bits of the ALU operands
//   S[2:0]      in   ALU select code that produced d
//   out_valid   out  registered result available
//   out_ready   in   downstream accepts the result this cycle
//   result      out  registered result word
//   op          out  registered select code
//   z,n,c,v     out  zero / negative / carry / overflow flags of result
//   sticky_v    out  overflow seen on any delivered result since last clear
//   clr_sticky  in   clears sticky_v; wins over a same-cycle set
//   dbg_state   out  buffer state (00 EMPTY, 01 ONE, 10 FULL)
// ============================================================================
module alu_result_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] d,
    input  logic        cout,
    input  logic        a31,
    input  logic        b31,
    input  logic [2:0]  S,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  op,
    output logic        z,
    output logic        n,
    output logic        c,
    output logic        v,
    output logic        sticky_v,
    input  logic        clr_sticky,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    logic [1:0]  state_q;
    logic [1:0]  state_d;

    // Skid entry: same contents as the main entry.
    logic [31:0] skid_result;
    logic [2:0]  skid_op;
    logic        skid_z;
    logic        skid_n;
    logic        skid_c;
    logic        skid_v;

    // Flags of the incoming word, computed at accept time.
    logic        in_z;
    logic        in_n;
    logic        in_c;
    logic        in_v;

    logic        accept;
    logic        deliver;
    logic        load_main_in;
    logic        load_main_skid;
    logic        load_skid;

    // ------------------------------------------------------------------
    // Flag generation. S[2]=0 selects add (S[0]=0) or subtract (S[0]=1);
    // for subtraction the effective b sign is inverted, hence S[0]^b31.
    // Logic ops (S[2]=1) never report carry or overflow.
    // ------------------------------------------------------------------
    always_comb begin
        in_z = (d == 32'd0);
        in_n = d[31];
        in_c = 1'b0;
        in_v = 1'b0;
        if (!S[2]) begin
            in_c = cout;
            in_v = (a31 == (S[0] ^ b31)) && (d[31] != a31);
        end
    end

    // ------------------------------------------------------------------
    // Handshake outputs. Both are gated by rst so that nothing is offered
    // or taken while reset is held, even before the first reset edge.
    // ------------------------------------------------------------------
    assign in_ready  = !rst && (state_q != ST_FULL);
    assign out_valid = !rst && ((state_q == ST_ONE) || (state_q == ST_FULL));
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Next-state and load selection.
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !deliver) begin
                    load_skid = 1'b1;
                    state_d   = ST_FULL;
                end else if (!accept && deliver) begin
                    state_d = ST_EMPTY;
                end else if (accept && deliver) begin
                    // Main is consumed and refilled on the same edge.
                    load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                // in_ready is 0 here, so no accept can coincide.
                if (deliver) begin
                    load_main_skid = 1'b1;
                    state_d        = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, entries and sticky overflow.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            result      <= 32'd0;
            op          <= 3'd0;
            z           <= 1'b0;
            n           <= 1'b0;
            c           <= 1'b0;
            v           <= 1'b0;
            skid_result <= 32'd0;
            skid_op     <= 3'd0;
            skid_z      <= 1'b0;
            skid_n      <= 1'b0;
            skid_c      <= 1'b0;
            skid_v      <= 1'b0;
            sticky_v    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (load_main_in) begin
                result <= d;
                op     <= S;
                z      <= in_z;
                n      <= in_n;
                c      <= in_c;
                v      <= in_v;
            end else if (load_main_skid) begin
                result <= skid_result;
                op     <= skid_op;
                z      <= skid_z;
                n      <= skid_n;
                c      <= skid_c;
                v      <= skid_v;
            end

            if (load_skid) begin
                skid_result <= d;
                skid_op     <= S;
                skid_z      <= in_z;
                skid_n      <= in_n;
                skid_c      <= in_c;
                skid_v      <= in_v;
            end

            // The overflow being accumulated is that of the entry leaving now.
            if (clr_sticky) begin
                sticky_v <= 1'b0;
            end else if (deliver && v) begin
                sticky_v <= 1'b1;
            end
        end
    end

endmodule
